// File: rtl/rotate_adapter.sv
// Frame-buffered image rotator: loads one raster frame, then replays it rotated
// by 0/90/180/270 degrees through a registered valid/ready output stage.
module rotate_adapter #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       rot_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int ADDR_W  = $clog2(NPIX);
  localparam int DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W   = (DIM_MAX > 2) ? $clog2(DIM_MAX) : 1;

  localparam logic [CNT_W-1:0]  W_M1  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  H_M1  = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] WA    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WM1A  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] HM1A  = ADDR_W'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic             pend_q, pend_d;
  logic             ovld_q, ovld_d;
  logic [PIX_W-1:0] odata_q, odata_d;
  logic             oeol_q, oeol_d;
  logic             olast_q, olast_d;
  logic             done_q, done_d;

  logic [PIX_W-1:0] mem [NPIX];

  logic [CNT_W-1:0]  ow_m1, oh_m1;
  logic [ADDR_W-1:0] oxa, oya, sx, sy, rd_addr, wr_addr;
  logic              in_fire, out_fire, out_load, row_end, frame_end;

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = ovld_q;
  assign out_data   = odata_q;
  assign out_eol    = oeol_q;
  assign out_last   = olast_q;
  assign frame_done = done_q;

  assign in_fire   = in_valid && (state_q == S_LOAD);
  assign out_fire  = ovld_q && out_ready;
  assign out_load  = (state_q == S_DRAIN) && pend_q && (!ovld_q || out_ready);

  // Odd modes transpose the output dimensions.
  assign ow_m1     = mode_q[0] ? H_M1 : W_M1;
  assign oh_m1     = mode_q[0] ? W_M1 : H_M1;
  assign row_end   = (ox_q == ow_m1);
  assign frame_end = row_end && (oy_q == oh_m1);

  assign oxa = ADDR_W'(ox_q);
  assign oya = ADDR_W'(oy_q);

  always_comb begin
    sx = oxa;
    sy = oya;
    case (mode_q)
      2'd1:    begin sx = oya;        sy = HM1A - oxa; end
      2'd2:    begin sx = WM1A - oxa; sy = HM1A - oya; end
      2'd3:    begin sx = WM1A - oya; sy = oxa;        end
      default: begin sx = oxa;        sy = oya;        end
    endcase
  end

  assign rd_addr = sy * WA + sx;
  assign wr_addr = ADDR_W'(y_q) * WA + ADDR_W'(x_q);

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_addr] <= in_data;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    pend_d  = pend_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    oeol_d  = oeol_q;
    olast_d = olast_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = rot_mode;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          if (x_q == W_M1) begin
            x_d = '0;
            y_d = y_q + C_ONE;
          end else begin
            x_d = x_q + C_ONE;
          end
          if ((x_q == W_M1) && (y_q == H_M1)) begin
            state_d = S_DRAIN;
            y_d     = '0;
            ox_d    = '0;
            oy_d    = '0;
            pend_d  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_fire && olast_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output register refills whenever it is empty or being emptied this cycle.
    if (out_load) begin
      ovld_d  = 1'b1;
      odata_d = mem[rd_addr];
      oeol_d  = row_end;
      olast_d = frame_end;
      if (frame_end) begin
        pend_d = 1'b0;
      end else if (row_end) begin
        ox_d = '0;
        oy_d = oy_q + C_ONE;
      end else begin
        ox_d = ox_q + C_ONE;
      end
    end else if (out_fire) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      pend_q  <= 1'b0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      oeol_q  <= 1'b0;
      olast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      pend_q  <= pend_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      oeol_q  <= oeol_d;
      olast_q <= olast_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_rotate_adapter.sv
// Directed bench for rotate_adapter on a 4x3 frame: table of per-mode frames
// plus a mid-drain reset sequence.
module tb_rotate_adapter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rot_mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_eol;
  logic       out_last;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  rotate_adapter #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rot_mode   (rot_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_eol    (out_eol),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       mode;
    logic             gap;
    logic             stall;
    logic             poke;
    logic [7:0]       base;
    logic [3:0]       ow;
    logic [11:0][3:0] seq;   // expected source index per output, element 0 first
  } vec_t;

  localparam logic [47:0] SEQ0 = 48'hBA9876543210;
  localparam logic [47:0] SEQ1 = 48'h37B26A159048;
  localparam logic [47:0] SEQ2 = 48'h0123456789AB;
  localparam logic [47:0] SEQ3 = 48'h840951A62B73;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Runs one frame; abort_n>0 resets the DUT after that many output transfers.
  task automatic do_frame(input vec_t v, input int abort_n);
    int i, n, cyc, first_vld, limit;
    logic fire, held, rdy, hl, he;
    logic [7:0] hd;
    limit = (abort_n > 0) ? abort_n : 12;
    @(negedge clk);
    start = 1'b1;
    rot_mode = v.mode;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_load", busy, 1);
    chk("in_ready_in_load", in_ready, 1);
    chk("out_valid_in_load", out_valid, 0);

    i = 0;
    cyc = 0;
    while (i < 12 && cyc < 200) begin
      in_valid = v.gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = 8'(v.base + 8'(i));
      start    = v.poke;
      rot_mode = v.poke ? ~v.mode : v.mode;
      fire     = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (fire) i++;
    end
    in_valid = 1'b0;
    chk("inputs_accepted", i, 12);

    n = 0;
    cyc = 0;
    first_vld = -1;
    held = 1'b0;
    hd = 8'd0;
    he = 1'b0;
    hl = 1'b0;
    while (n < limit && cyc < 400) begin
      if (first_vld < 0 && out_valid) first_vld = cyc;
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_eol", out_eol, he);
        chk("stall_last", out_last, hl);
      end
      rdy = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = rdy;
      start     = v.poke && (n < 11);
      rot_mode  = v.poke ? ~v.mode : v.mode;
      if (out_valid && rdy) begin
        chk("out_data", out_data, 8'(v.base + 8'(v.seq[n])));
        chk("out_eol", out_eol, ((n + 1) % int'(v.ow)) == 0);
        chk("out_last", out_last, n == 11);
        n++;
      end
      held = out_valid && !rdy;
      hd = out_data;
      he = out_eol;
      hl = out_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rot_mode = v.mode;
    chk("outputs_seen", n, limit);
    chk("first_valid_latency", first_vld, 1);

    if (abort_n > 0) begin
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_eol", out_eol, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_frame_done", frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("post_abort_idle_valid", out_valid, 0);
        chk("post_abort_idle_busy", busy, 0);
      end
    end else begin
      chk("end_out_valid", out_valid, 0);
      chk("end_frame_done", frame_done, 1);
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("frame_done_one_cycle", frame_done, 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, gap: 1'b0, stall: 1'b0, poke: 1'b0, base: 8'd0,    ow: 4'd4, seq: SEQ0};
    vecs[1] = '{mode: 2'd1, gap: 1'b0, stall: 1'b0, poke: 1'b0, base: 8'd0,    ow: 4'd3, seq: SEQ1};
    vecs[2] = '{mode: 2'd2, gap: 1'b0, stall: 1'b0, poke: 1'b0, base: 8'd0,    ow: 4'd4, seq: SEQ2};
    vecs[3] = '{mode: 2'd3, gap: 1'b0, stall: 1'b0, poke: 1'b0, base: 8'd0,    ow: 4'd3, seq: SEQ3};
    vecs[4] = '{mode: 2'd1, gap: 1'b1, stall: 1'b1, poke: 1'b0, base: 8'd0,    ow: 4'd3, seq: SEQ1};
    vecs[5] = '{mode: 2'd3, gap: 1'b1, stall: 1'b1, poke: 1'b1, base: 8'h20,   ow: 4'd3, seq: SEQ3};
    vecs[6] = '{mode: 2'd0, gap: 1'b0, stall: 1'b0, poke: 1'b0, base: 8'd100,  ow: 4'd4, seq: SEQ0};

    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_eol", out_eol, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) do_frame(vecs[t], 0);

    do_frame(vecs[1], 5);
    do_frame(vecs[6], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_adapter.md
ROTATE_ADAPTER -- requirements
Module: rotate_adapter

Interface
REQ-001 Parameter IMG_W, default 256, image width in pixels (>=2).
REQ-002 Parameter IMG_H, default 256, image height in pixels (>=2).
REQ-003 Parameter PIX_W, default 8, pixel width in bits; derived localparam ADDR_W = clog2(IMG_W*IMG_H).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a frame; sampled only in IDLE.
REQ-007 rot_mode  input  2  0=none, 1=90 CW, 2=180, 3=270 CW; latched on accepted start.
REQ-008 in_valid / in_ready / in_data  input / output / PIX_W  raster-order pixel input, valid/ready handshake.
REQ-009 out_valid / out_ready / out_data  output / input / PIX_W  rotated raster-order pixel output, valid/ready handshake.
REQ-010 out_eol  output  1  qualifies out_data as last pixel of an output row.
REQ-011 out_last  output  1  qualifies out_data as last pixel of the frame.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the last output transfer.

Function
REQ-014 FSM states IDLE, LOAD, DRAIN; IDLE->LOAD on start; LOAD->DRAIN after the IMG_W*IMG_H-th input transfer; DRAIN->IDLE after the final output transfer.
REQ-015 Internal frame store: IMG_W*IMG_H words of PIX_W bits, one write port, combinational read; no reset of contents.
REQ-016 in_ready shall be 1 only in LOAD; an input transfer is in_valid & in_ready.
REQ-017 LOAD: each transfer writes in_data at address y*IMG_W+x; x increments, wraps IMG_W-1->0 with y+1; one pixel per cycle max.
REQ-018 Output dimensions: OW=IMG_W, OH=IMG_H for modes 0/2; OW=IMG_H, OH=IMG_W for modes 1/3.
REQ-019 DRAIN walks output coords (ox,oy) in raster order, ox wrapping OW-1->0 with oy+1.
REQ-020 Source mapping: mode0 (ox,oy); mode1 (x=oy, y=IMG_H-1-ox); mode2 (x=IMG_W-1-ox, y=IMG_H-1-oy); mode3 (x=IMG_W-1-oy, y=ox).
REQ-021 out_data/out_valid/out_eol/out_last are registered; the output register loads the next pixel when (!out_valid | out_ready) and pixels remain.
REQ-022 First out_valid asserts the cycle after entering DRAIN; sustained throughput one pixel/cycle with out_ready held high.
REQ-023 While out_valid & !out_ready, out_data, out_eol, out_last shall hold stable.
REQ-024 out_eol=1 when ox==OW-1; out_last=1 when ox==OW-1 and oy==OH-1.
REQ-025 After the out_last transfer: out_valid=0 next cycle, frame_done=1 for exactly that cycle, state IDLE.
REQ-026 start outside IDLE and rot_mode changes mid-frame are ignored.
REQ-027 start and frame_done may coincide with nothing else: start in the frame_done cycle is accepted (state already IDLE).
REQ-028 Counters sized to hold max(IMG_W,IMG_H)-1; address arithmetic done at ADDR_W bits, no truncation.

Reset
REQ-029 rst_n low at any time: state IDLE, all counters 0, latched mode 0, in_ready=0, out_valid=0, out_data=0, out_eol=0, out_last=0, busy=0, frame_done=0.
REQ-030 Reset mid-LOAD or mid-DRAIN abandons the frame; no further output until a new start.

Verification (IMG_W=4, IMG_H=3, PIX_W=8, inputs 0..11 in order)
REQ-031 mode0, out_ready=1 -> outputs 0..11, out_eol on 3,7,11, out_last on 11, frame_done next cycle.
REQ-032 mode1 -> 8,4,0,9,5,1,10,6,2,11,7,3; out_eol every 3rd pixel; out_last on 3.
REQ-033 mode2 -> 11..0; mode3 -> 3,7,11,2,6,10,1,5,9,0,4,8.
REQ-034 mode1, out_ready toggled pseudo-randomly, in_valid gapped -> same sequence as REQ-032, data stable while stalled, no drop/duplicate.
REQ-035 rst_n low during DRAIN after 5 outputs -> all outputs reset values; new start with mode0 and inputs 100..111 -> outputs 100..111.
REQ-036 start pulsed during LOAD and DRAIN with different rot_mode -> ignored; frame completes with original mode.
